mat_fetch_ctrl: RTL and testbench
=================================

# mat_fetch_ctrl

Avalon-MM read master and loader that feeds the matrix-vector MAC array. On `start` it fetches DEPTH matrix-row lines plus one vector line from the memory wrapper, one 64-bit word per line. It serialises each word into bytes and writes them into the per-row A FIFOs and the shared B FIFO, then pulses `fetch_done`. It sits directly upstream of `mat_vec_mult` and replaces the ad-hoc read logic in the board top level.

## Interface
- `DEPTH`, 8, number of matrix rows and number of bytes per memory line
- `DATA_WIDTH`, 8, element width in bits
- `ADDR_WIDTH`, 32, Avalon address width
- `BASE_ADDR`, 0, word address of matrix row 0; the vector line is at `BASE_ADDR+DEPTH`

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `start`  in  1  begin a fetch; sampled only in IDLE
- `avm_address`  out  ADDR_WIDTH  word address of the current line
- `avm_read`  out  1  read request
- `avm_readdata`  in  DEPTH*DATA_WIDTH  returned line
- `avm_readdatavalid`  in  1  `avm_readdata` is valid
- `avm_waitrequest`  in  1  slave stall
- `fifo_din`  out  DATA_WIDTH  byte to write into the FIFOs
- `a_wren`  out  DEPTH  one-hot write enable for A FIFO row r
- `b_wren`  out  1  write enable for the B FIFO
- `mac_clr`  out  1  one-cycle clear to the MAC array
- `busy`  out  1  high in every state except IDLE
- `fetch_done`  out  1  one-cycle completion pulse
- `fetch_err`  out  1  sticky timeout flag; present only with `FETCH_TIMEOUT_EN`

## Operation
- States: IDLE, REQ, WAIT_DATA, UNPACK, DONE (plus ERR with `FETCH_TIMEOUT_EN`).
- IDLE, `start`=1:
  - clear the line counter to 0
  - pulse `mac_clr`
  - go to REQ
- REQ:
  - `avm_read`=1 and `avm_address`=`BASE_ADDR+line`, both held stable while `avm_waitrequest`=1
  - the request is accepted on the cycle `avm_read & !avm_waitrequest`; go to WAIT_DATA on that cycle
- WAIT_DATA:
  - `avm_read`=0
  - on `avm_readdatavalid`, capture `avm_readdata` into the line register, clear the byte counter, go to UNPACK
- UNPACK:
  - runs for DEPTH cycles, one per byte; byte k is `line_reg[k*DATA_WIDTH +: DATA_WIDTH]`, byte 0 first
  - `fifo_din` carries byte k on cycle k
  - for lines 0..DEPTH-1, `a_wren[line]`=1 on every UNPACK cycle
  - for line DEPTH, `b_wren`=1 on every UNPACK cycle
  - after byte DEPTH-1: if line==DEPTH go to DONE, otherwise increment line and go to REQ
- DONE: `fetch_done`=1 for exactly one cycle, then go to IDLE.
- Only one read is outstanding at a time.
- `avm_readdatavalid` is ignored in every state except WAIT_DATA.
- `start` is ignored whenever `busy`=1.
- Counter widths: line counter is $clog2(DEPTH+1) bits; byte counter is $clog2(DEPTH) bits. Neither counter wraps within a fetch.

## Timing
- Reset values: `avm_address`=`BASE_ADDR`, and `avm_read`, `fifo_din`, `a_wren`, `b_wren`, `mac_clr`, `busy`, `fetch_done`, `fetch_err` all 0. State = IDLE.
- All outputs are registered or decoded from state plus counters only; there is no combinational path from any input to any output.
- Cycle 0 = `start` sampled in IDLE:
  - `mac_clr`=1 in cycle 1
  - REQ begins in cycle 1 with `avm_read`=1
- Per-line cost is 1 + W + L + DEPTH cycles, where W is waitrequest cycles and L is readdatavalid latency (≥1).
- With zero wait and L=1, a full fetch is (DEPTH+1)*(DDEPTH+2) cycles, i.e. 90 cycles for DEPTH=8, plus 1 DONE cycle. `fetch_done` is high in cycle 91.
- At most one of `a_wren` / `b_wren` bits is high in any cycle.
- Reset mid-fetch:
  - immediately returns to IDLE with all outputs at reset values
  - partially loaded FIFOs are the consumer's responsibility; the next `mac_clr` resets them
  - any in-flight read response is discarded

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - a 16-bit watchdog counts cycles spent in REQ or WAIT_DATA for the current line and restarts for each line
  - at 65535 the block enters ERR: `fetch_err`=1, `busy`=1, no further writes
  - ERR exits only on reset
- `FETCH_TIMEOUT_EN` undefined: no watchdog, no ERR state, and `fetch_err` is tied 0.

## Structure
- Shared package `mat_pkg`: state enum, `DEPTH` and `DATA_WIDTH` defaults, and the timeout constant. `mat_vec_mult` and the top level reuse the same package.
- One sub-module, `line_serializer`: parallel-load register plus byte counter that emits `fifo_din` and a `last` flag. The FSM owns sequencing and write-enable decode.

## Test plan
- Memory model with line n = bytes n*8+k (k=0..7), zero wait, latency 1 → A FIFO row r receives 8r..8r+7 and B receives 64..71. `fetch_done` is high in cycle 91, with exactly 72 write strobes total.
- `avm_waitrequest` held high for 5 cycles on line 3 → `avm_address`=3 and `avm_read`=1 stay stable through the stall, and the fetch completes 5 cycles later with identical FIFO contents.
- Spurious `avm_readdatavalid` pulsed during REQ and UNPACK → ignored; no extra writes and no data corruption.
- `start` re-asserted while `busy` → ignored, with a single `mac_clr` and a single `fetch_done` for the fetch.
- `rst_n` low during UNPACK of line 4 → all outputs return to 0 asynchronously; a new `start` after release refetches from line 0 correctly.
- With `FETCH_TIMEOUT_EN` and `avm_readdatavalid` never asserted → `fetch_err`=1 after 65535 cycles, no `fetch_done`, and the flag stays set until reset.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-vector datapath: FSM states, default sizes
// and the fetch watchdog limit.
package mat_pkg;
  localparam int DEPTH_DEF      = 8;
  localparam int DATA_WIDTH_DEF = 8;
  localparam logic [15:0] FETCH_TIMEOUT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_UNPACK,
    S_DONE,
    S_ERR
  } fetch_state_t;
endpackage

// File: rtl/mat_fetch_ctrl_if.sv
// Avalon-MM read channel between the fetch controller and the memory wrapper.
interface mat_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_W     = 64
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_readdatavalid;
  logic                  avm_waitrequest;

  modport master (output avm_address, avm_read,
                  input  avm_readdata, avm_readdatavalid, avm_waitrequest);
  modport slave  (input  avm_address, avm_read,
                  output avm_readdata, avm_readdatavalid, avm_waitrequest);
endinterface

// File: rtl/mat_fetch_ctrl_line_serializer.sv
// Holds one fetched memory line and steps through it a byte per cycle, byte 0 first.
module line_serializer #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_load,
  input  logic                        i_adv,
  input  logic [DEPTH*DATA_WIDTH-1:0] i_line,
  output logic [DATA_WIDTH-1:0]       o_byte,
  output logic                        o_last
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH*DATA_WIDTH-1:0] r_line;
  logic [CW-1:0]               r_cnt;

  // counter parks on the last byte so it never wraps within a line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_line <= i_line;
      r_cnt  <= '0;
    end else if (i_adv && !o_last) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_byte = r_line[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH];
  assign o_last = (r_cnt == CW'(DEPTH-1));
endmodule

// File: rtl/mat_fetch_ctrl.sv
// Fetches DEPTH matrix rows plus one vector line and loads them bytewise into
// the A/B FIFOs. Define FETCH_TIMEOUT_EN to add the per-line watchdog and ERR state.
module mat_fetch_ctrl
  import mat_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mat_fetch_ctrl_if.master      avm,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic [DEPTH-1:0]      a_wren,
  output logic                  b_wren,
  output logic                  mac_clr,
  output logic                  busy,
  output logic                  fetch_done,
  output logic                  fetch_err
);
  localparam int LW = $clog2(DEPTH+1);

  fetch_state_t  r_state;
  logic [LW-1:0] r_line;
  logic          r_mac_clr;
  logic          w_last;
  logic          w_load;
  logic          w_unpack;
  logic          w_vec_line;
`ifdef FETCH_TIMEOUT_EN
  logic [15:0]   r_wdog;
`endif

  assign w_load     = (r_state == S_WAIT_DATA) && avm.avm_readdatavalid;
  assign w_unpack   = (r_state == S_UNPACK);
  assign w_vec_line = (r_line == LW'(DEPTH));

  line_serializer #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_adv  (w_unpack),
    .i_line (avm.avm_readdata),
    .o_byte (fifo_din),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_line    <= '0;
      r_mac_clr <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_wdog    <= '0;
`endif
    end else begin
      r_mac_clr <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_line    <= '0;
          r_mac_clr <= 1'b1;
          r_state   <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
          r_wdog    <= '0;
`endif
        end
        S_REQ: begin
`ifdef FETCH_TIMEOUT_EN
          r_wdog <= r_wdog + 16'd1;
          if (r_wdog == FETCH_TIMEOUT) r_state <= S_ERR;
          else
`endif
          if (!avm.avm_waitrequest) r_state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
`ifdef FETCH_TIMEOUT_EN
          r_wdog <= r_wdog + 16'd1;
          if (r_wdog == FETCH_TIMEOUT) r_state <= S_ERR;
          else
`endif
          if (avm.avm_readdatavalid) r_state <= S_UNPACK;
        end
        S_UNPACK: if (w_last) begin
          if (w_vec_line) r_state <= S_DONE;
          else begin
            r_line  <= r_line + 1'b1;
            r_state <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end
        S_DONE:  r_state <= S_IDLE;
`ifdef FETCH_TIMEOUT_EN
        S_ERR:   r_state <= S_ERR;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // every output is a decode of registered state, never of an input
  assign avm.avm_read    = (r_state == S_REQ);
  assign avm.avm_address = BASE_ADDR + ADDR_WIDTH'(r_line);
  assign a_wren          = (w_unpack && !w_vec_line) ? (DEPTH'(1) << r_line) : '0;
  assign b_wren          = w_unpack && w_vec_line;
  assign mac_clr         = r_mac_clr;
  assign busy            = (r_state != S_IDLE);
  assign fetch_done      = (r_state == S_DONE);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err       = (r_state == S_ERR);
`else
  assign fetch_err       = 1'b0;
`endif
endmodule

// File: tb/tb_mat_fetch_ctrl.sv
// Directed bench for mat_fetch_ctrl: memory model with line n = bytes 8n+k.
module tb_mat_fetch_ctrl;
  localparam int D  = 8;
  localparam int DW = 8;
  localparam int AW = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;

  mat_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_W(D*DW)) bus();

  logic [DW-1:0] fifo_din;
  logic [D-1:0]  a_wren;
  logic          b_wren, mac_clr, busy, fetch_done, fetch_err;

  mat_fetch_ctrl #(.DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(32'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .avm        (bus),
    .fifo_din   (fifo_din),
    .a_wren     (a_wren),
    .b_wren     (b_wren),
    .mac_clr    (mac_clr),
    .busy       (busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  // memory model: zero wait unless stalling stall_addr, read latency 1
  int             stall_addr = -1;
  int             stall_cnt  = 0;
  bit             spur_en    = 1'b0;
  logic           r_rdv      = 1'b0;
  logic [D*DW-1:0] r_rdata   = '0;
  logic           wreq, spur;

  assign wreq = bus.avm_read && (int'(bus.avm_address) == stall_addr) && (stall_cnt < 5);
  assign spur = spur_en && (bus.avm_read || (|a_wren) || b_wren);
  assign bus.avm_waitrequest   = wreq;
  assign bus.avm_readdatavalid = r_rdv | spur;
  assign bus.avm_readdata      = spur ? {D{8'hEE}} : r_rdata;

  always @(posedge clk) begin
    r_rdv <= 1'b0;
    if (bus.avm_read && !wreq) begin
      r_rdv <= 1'b1;
      for (int k = 0; k < D; k++) r_rdata[k*DW +: DW] <= 8'(int'(bus.avm_address)*8 + k);
    end
    if (int'(bus.avm_address) != stall_addr) stall_cnt <= 0;
    else if (wreq) stall_cnt <= stall_cnt + 1;
  end

  int errs = 0, checks = 0, cyc = 0, t0 = 0;
  logic [7:0] a_mem [D][D];
  int         a_n [D];
  logic [7:0] b_mem [D];
  int b_n, nstb, nmulti, nclr, ndone, done_cyc;

  task automatic clear_sb();
    for (int r = 0; r < D; r++) a_n[r] = 0;
    b_n = 0; nstb = 0; nmulti = 0; nclr = 0; ndone = 0; done_cyc = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int r = 0; r < D; r++)
      if (a_wren[r]) begin
        if (a_n[r] < D) a_mem[r][a_n[r]] = fifo_din;
        a_n[r]++;
      end
    if (b_wren) begin
      if (b_n < D) b_mem[b_n] = fifo_din;
      b_n++;
    end
    nstb += $countones(a_wren) + int'(b_wren);
    if ($countones({a_wren, b_wren}) > 1) nmulti++;
    if (mac_clr) nclr++;
    if (fetch_done) begin ndone++; done_cyc = cyc - t0; end
  endtask

  task automatic launch();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (fetch_done) ok = 1'b1;
    end
  endtask

  // rows 0..7 of A plus the B line (index 8) that do not hold the expected bytes
  function automatic int bad_rows();
    int n = 0;
    for (int r = 0; r < D; r++) begin
      bit bad = (a_n[r] != D);
      for (int k = 0; k < D && !bad; k++) if (a_mem[r][k] !== 8'(8*r + k)) bad = 1'b1;
      if (bad) n++;
    end
    begin
      bit bad = (b_n != D);
      for (int k = 0; k < D && !bad; k++) if (b_mem[k] !== 8'(8*D + k)) bad = 1'b1;
      if (bad) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.avm_read, a_wren, b_wren, mac_clr, busy, fetch_done, fetch_err} !== '0) begin
      errs++; $display("FAIL reset_ctrl: got %b want all 0",
        {bus.avm_read, a_wren, b_wren, mac_clr, busy, fetch_done, fetch_err});
    end
    checks++;
    if (bus.avm_address !== 32'd0 || fifo_din !== 8'd0) begin
      errs++; $display("FAIL reset_data: addr=%0h din=%0h want 0/0", bus.avm_address, fifo_din);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_fetch();
    bit ok;
    clear_sb();
    launch();
    checks++;
    if (mac_clr !== 1'b1 || bus.avm_read !== 1'b1 || bus.avm_address !== 32'd0) begin
      errs++; $display("FAIL cycle1: mac_clr=%b read=%b addr=%0d want 1/1/0",
        mac_clr, bus.avm_read, bus.avm_address);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || done_cyc != 91) begin
      errs++; $display("FAIL full_done_cycle: got %0d want 91", done_cyc);
    end
    checks++;
    if (nstb != 72 || nmulti != 0) begin
      errs++; $display("FAIL full_strobes: got %0d (multi %0d) want 72 (0)", nstb, nmulti);
    end
    checks++;
    if (bad_rows() != 0) begin
      errs++; $display("FAIL full_contents: got %0d bad lines want 0", bad_rows());
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || ndone != 1) begin
      errs++; $display("FAIL full_idle: busy=%b dones=%0d want 0/1", busy, ndone);
    end
  endtask

  task automatic test_stall();
    bit ok, seen;
    int stable;
    clear_sb();
    stall_addr = 3;
    launch();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (bus.avm_read && bus.avm_address == 32'd3) seen = 1'b1;
    end
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.avm_read === 1'b1 && bus.avm_address === 32'd3) stable++;
    end
    checks++;
    if (!seen || stable != 5) begin
      errs++; $display("FAIL stall_hold: got %0d stable cycles want 5", stable);
    end
    wait_done(200, ok);
    stall_addr = -1;
    checks++;
    if (!ok || done_cyc != 96) begin
      errs++; $display("FAIL stall_done_cycle: got %0d want 96", done_cyc);
    end
    checks++;
    if (bad_rows() != 0 || nstb != 72) begin
      errs++; $display("FAIL stall_contents: bad=%0d strobes=%0d want 0/72", bad_rows(), nstb);
    end
    tick();
  endtask

  task automatic test_spurious();
    bit ok;
    clear_sb();
    spur_en = 1'b1;
    launch();
    wait_done(200, ok);
    spur_en = 1'b0;
    checks++;
    if (!ok || done_cyc != 91) begin
      errs++; $display("FAIL spur_done_cycle: got %0d want 91", done_cyc);
    end
    checks++;
    if (bad_rows() != 0 || nstb != 72) begin
      errs++; $display("FAIL spur_contents: bad=%0d strobes=%0d want 0/72", bad_rows(), nstb);
    end
    tick();
  endtask

  task automatic test_start_busy();
    bit ok;
    clear_sb();
    launch();
    for (int i = 0; i < 20; i++) tick();
    start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, ok);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (nclr != 1 || ndone != 1) begin
      errs++; $display("FAIL busy_start: clr=%0d done=%0d want 1/1", nclr, ndone);
    end
    checks++;
    if (!ok || done_cyc != 91 || bad_rows() != 0) begin
      errs++; $display("FAIL busy_fetch: done_cycle=%0d bad=%0d want 91/0", done_cyc, bad_rows());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    clear_sb();
    launch();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (a_wren[4]) seen = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {bus.avm_read, a_wren, b_wren, mac_clr, busy, fetch_done} !== '0
        || bus.avm_address !== 32'd0 || fifo_din !== 8'd0) begin
      errs++; $display("FAIL reset_mid: seen=%b ctrl=%b addr=%0d din=%0h want 1/0/0/0", seen,
        {bus.avm_read, a_wren, b_wren, mac_clr, busy, fetch_done}, bus.avm_address, fifo_din);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_sb();
    launch();
    wait_done(200, ok);
    checks++;
    if (!ok || done_cyc != 91 || bad_rows() != 0 || nstb != 72) begin
      errs++; $display("FAIL refetch: done_cycle=%0d bad=%0d strobes=%0d want 91/0/72",
        done_cyc, bad_rows(), nstb);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_fetch();
    test_stall();
    test_spurious();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
